// File: rtl/cmd_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cmd_uart_pkg
//  Brief    : Shared constants for the remote command UART link: response
//             codes, accepted opcode nibbles and byte-FSM state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package cmd_uart_pkg;

    // Response bytes
    localparam logic [7:0] c_ack = 8'hA5;
    localparam logic [7:0] c_nak = 8'h5A;

    // Opcode nibbles (cmd[15:12]) accepted when opcode filtering is built in
    localparam logic [3:0] c_op_a = 4'h2;
    localparam logic [3:0] c_op_b = 4'h3;
    localparam logic [3:0] c_op_c = 4'h4;

    // Byte-FSM states: which half of the command the next byte fills
    localparam logic [0:0] c_st_high = 1'b0;
    localparam logic [0:0] c_st_low  = 1'b1;

    // True when the opcode nibble belongs to the accepted set
    function automatic logic opcode_valid(input logic [3:0] op);
        return (op == c_op_a) || (op == c_op_b) || (op == c_op_c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Brief    : 8N1 UART transmitter. A start request while idle latches the
//             byte into a 10-bit frame register whose LSB drives the line
//             directly, so the serial output is registered. Requests while
//             busy are ignored. o_done is sticky until the next accepted
//             request.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_done
);

    localparam int c_cnt_w = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_baud_last = c_cnt_w'(BAUD_DIV - 1);

    logic [9:0]         r_shift;
    logic [c_cnt_w-1:0] r_baud_cnt;
    logic [3:0]         r_bit_cnt;
    logic               r_busy;
    logic               r_done;

    // Frame sequencing: accept, shift one bit per baud period, finish after stop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift    <= '1;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else if (!r_busy) begin
            if (i_start) begin
                // {stop, data LSB..MSB, start}; start bit appears next cycle
                r_shift    <= {1'b1, i_data, 1'b0};
                r_baud_cnt <= '0;
                r_bit_cnt  <= '0;
                r_busy     <= 1'b1;
                r_done     <= 1'b0;
            end
        end else if (r_baud_cnt == c_baud_last) begin
            r_baud_cnt <= '0;
            if (r_bit_cnt == 4'd9) begin
                // Stop bit complete; frame register already holds all ones
                r_bit_cnt <= '0;
                r_busy    <= 1'b0;
                r_done    <= 1'b1;
            end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
                r_shift   <= {1'b1, r_shift[9:1]};
            end
        end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
        end
    end

    assign o_tx   = r_shift[0];
    assign o_done = r_done;

endmodule
`default_nettype wire

// File: rtl/cmd_uart_responder.sv
`default_nettype none
// ============================================================================
//  Module   : cmd_uart_responder
//  Brief    : Receives a 16-bit command as two 8N1 bytes (high byte first),
//             hands it to the command processor with a cmd_rdy/clr_cmd_rdy
//             handshake and transmits a one-byte response on trmt.
//             Optional build macro OPCODE_FILTER_EN: commands whose opcode
//             nibble is not 2, 3 or 4 are dropped and a NAK (0x5A) is sent
//             automatically when the transmitter is idle.
//  Revision : 1.0 - initial release
// ============================================================================
module cmd_uart_responder
    import cmd_uart_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done,
    output logic        rx_err
);

    localparam int c_cnt_w = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_baud_last = c_cnt_w'(BAUD_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_baud_mid  = c_cnt_w'(BAUD_DIV / 2);

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------
    logic               r_rx_meta;
    logic               r_rx_sync;
    logic               r_rx_prev;
    logic               r_rx_busy;
    logic [c_cnt_w-1:0] r_rx_baud;
    logic [3:0]         r_rx_bit;
    logic [7:0]         r_rx_shift;

    logic               w_rx_start;
    logic               w_rx_sample;
    logic               w_stop_sample;
    logic               w_byte_good;
    logic               w_byte_bad;

    // Two-flop synchronizer plus one history flop for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_rx_start    = !r_rx_busy && r_rx_prev && !r_rx_sync;
    assign w_rx_sample   = r_rx_busy && (r_rx_baud == c_baud_mid);
    assign w_stop_sample = w_rx_sample && (r_rx_bit == 4'd9);
    assign w_byte_good   = w_stop_sample && r_rx_sync;
    assign w_byte_bad    = w_stop_sample && !r_rx_sync;

    // Bit receiver: bit 0 is the start bit, 1..8 data LSB first, 9 the stop;
    // it goes idle at the stop-bit sample so the next start edge is caught
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_busy  <= 1'b0;
            r_rx_baud  <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else if (w_rx_start) begin
            r_rx_busy <= 1'b1;
            r_rx_baud <= '0;
            r_rx_bit  <= '0;
        end else if (r_rx_busy) begin
            if (w_stop_sample) begin
                r_rx_busy <= 1'b0;
                r_rx_baud <= '0;
                r_rx_bit  <= '0;
            end else begin
                if (r_rx_baud == c_baud_last) begin
                    r_rx_baud <= '0;
                    r_rx_bit  <= r_rx_bit + 4'd1;
                end else begin
                    r_rx_baud <= r_rx_baud + 1'b1;
                end
                if (w_rx_sample && (r_rx_bit != 4'd0)) begin
                    r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Byte FSM and command register
    // ------------------------------------------------------------------
    logic [0:0]  r_state;
    logic [15:0] r_cmd;
    logic        r_cmd_rdy;
    logic        r_rx_err;

    logic        w_cmd_done;
    logic        w_op_ok;
    logic        w_accept;
    logic        w_tx_start;
    logic [7:0]  w_tx_data;

    assign w_cmd_done = w_byte_good && (r_state == c_st_low);
    assign w_accept   = w_cmd_done && w_op_ok;

`ifdef OPCODE_FILTER_EN
    logic w_nak_req;
    assign w_op_ok    = opcode_valid(r_cmd[15:12]);
    assign w_nak_req  = w_cmd_done && !w_op_ok;
    // An autonomous NAK takes the transmitter ahead of an external trmt
    assign w_tx_start = trmt || w_nak_req;
    assign w_tx_data  = w_nak_req ? c_nak : resp;
`else
    assign w_op_ok    = 1'b1;
    assign w_tx_start = trmt;
    assign w_tx_data  = resp;
`endif

    // Assemble high then low byte; a framing error restarts at the high byte
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_high;
            r_cmd     <= '0;
            r_cmd_rdy <= 1'b0;
            r_rx_err  <= 1'b0;
        end else begin
            r_rx_err <= w_byte_bad;
            if (w_byte_bad) begin
                r_state <= c_st_high;
            end else if (w_byte_good) begin
                if (r_state == c_st_high) begin
                    r_cmd[15:8] <= r_rx_shift;
                    r_state     <= c_st_low;
                end else begin
                    r_state <= c_st_high;
                    if (w_accept) begin
                        r_cmd[7:0] <= r_rx_shift;
                    end
                end
            end
            // A new start bit in HIGH means the previous command is superseded
            if (w_accept) begin
                r_cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy || (w_rx_start && (r_state == c_st_high))) begin
                r_cmd_rdy <= 1'b0;
            end
        end
    end

    assign cmd     = r_cmd;
    assign cmd_rdy = r_cmd_rdy;
    assign rx_err  = r_rx_err;

    // ------------------------------------------------------------------
    // Transmit path
    // ------------------------------------------------------------------
    uart_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_tx (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_tx_start),
        .i_data  (w_tx_data),
        .o_tx    (TX),
        .o_done  (tx_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_cmd_uart_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cmd_uart_responder
//  Brief    : Self-checking bench for cmd_uart_responder: table of command
//             vectors, hand-written transmit/reset sequences and random
//             commands checked against a byte-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_uart_responder;
    import cmd_uart_pkg::*;

    localparam int BD = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RX = 1'b1;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        trmt = 1'b0;
    logic        tx_done;
    logic        rx_err;

    always #5 clk = ~clk;

    cmd_uart_responder #(.BAUD_DIV(BD)) dut (
        .clk         (clk),
        .rst         (rst),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .trmt        (trmt),
        .tx_done     (tx_done),
        .rx_err      (rx_err)
    );

    int total = 0;
    int bad   = 0;
    int err_cycles = 0;
    int tx_low = 0;

    // Count high cycles of rx_err and low cycles of TX
    always @(posedge clk) begin
        #1;
        if (rx_err === 1'b1) err_cycles++;
        if (TX === 1'b0) tx_low++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        RX = 1'b0;
        cyc(BD);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            cyc(BD);
        end
        RX = stop;
        cyc(BD);
        RX = 1'b1;
    endtask

    task automatic send_cmd(input logic [7:0] hi, input logic [7:0] lo, input int gap);
        send_byte(hi, 1'b1);
        cyc(gap);
        send_byte(lo, 1'b1);
    endtask

    task automatic pulse_clr();
        clr_cmd_rdy = 1'b1;
        cyc(1);
        clr_cmd_rdy = 1'b0;
    endtask

    // Wait (bounded) for a TX start bit and decode the frame at bit centres
    task automatic capture_tx(output logic [7:0] b, output logic ok);
        int n;
        n = 0;
        ok = 1'b0;
        b = 8'h00;
        while (TX !== 1'b0 && n < 40 * BD) begin
            cyc(1);
            n++;
        end
        if (TX === 1'b0) begin
            cyc(BD / 2);
            ok = (TX === 1'b0);
            for (int i = 0; i < 8; i++) begin
                cyc(BD);
                b[i] = TX;
            end
            cyc(BD);
            ok = ok && (TX === 1'b1);
        end
    endtask

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        int          mode;     // 0 good command, 1 first byte bad stop, 2 second byte bad stop
        logic [15:0] exp_cmd;
        logic        exp_rdy;
        int          exp_err;
    } vec_t;

    vec_t vecs [6];

    logic        txs [0:10*BD+1];
    logic        dns [0:10*BD+1];
    logic [7:0]  cap_b;
    logic        cap_ok;
    logic [7:0]  dec;
    logic [7:0]  r_hi;
    logic [7:0]  r_lo;
    logic        m_valid;
    logic        m_pending;
    int          hold_bad;
    int          e0;
    int          t0;
    int          gap;
    logic        skip;

    initial begin
        vecs[0] = '{8'h4F, 8'hFF, 0, 16'h4FFF, 1'b1, 0};
        vecs[1] = '{8'h55, 8'h00, 1, 16'h0000, 1'b0, 1};
        vecs[2] = '{8'h2A, 8'h00, 0, 16'h2A00, 1'b1, 0};
        vecs[3] = '{8'h3C, 8'hA5, 2, 16'h0000, 1'b0, 1};
        vecs[4] = '{8'h41, 8'h7E, 0, 16'h417E, 1'b1, 0};
        vecs[5] = '{8'h2F, 8'h80, 0, 16'h2F80, 1'b1, 0};

        // ---------------- reset state ----------------
        rst = 1'b1;
        cyc(3);
        check("reset_TX", TX, 1);
        check("reset_cmd", cmd, 0);
        check("reset_cmd_rdy", cmd_rdy, 0);
        check("reset_tx_done", tx_done, 0);
        check("reset_rx_err", rx_err, 0);
        rst = 1'b0;
        hold_bad = 0;
        for (int k = 0; k < 100; k++) begin
            cyc(1);
            if (TX !== 1'b1 || cmd_rdy !== 1'b0 || cmd !== 16'h0000 ||
                tx_done !== 1'b0 || rx_err !== 1'b0) hold_bad++;
        end
        check("reset_idle_hold", hold_bad, 0);

        // ---------------- table-driven receive vectors ----------------
        for (int v = 0; v < 6; v++) begin
            e0 = err_cycles;
            case (vecs[v].mode)
                0: send_cmd(vecs[v].hi, vecs[v].lo, 0);
                1: send_byte(vecs[v].hi, 1'b0);
                default: begin
                    send_byte(vecs[v].hi, 1'b1);
                    send_byte(vecs[v].lo, 1'b0);
                end
            endcase
            cyc(BD);
            check($sformatf("vec%0d_rdy", v), cmd_rdy, vecs[v].exp_rdy);
            check($sformatf("vec%0d_err_cycles", v), err_cycles - e0, vecs[v].exp_err);
            if (vecs[v].exp_rdy) begin
                check($sformatf("vec%0d_cmd", v), cmd, vecs[v].exp_cmd);
                cyc(20);
                check($sformatf("vec%0d_rdy_held", v), cmd_rdy, 1);
                pulse_clr();
                check($sformatf("vec%0d_rdy_cleared", v), cmd_rdy, 0);
                check($sformatf("vec%0d_cmd_stable", v), cmd, vecs[v].exp_cmd);
            end
        end

        // ---------------- transmit frame, busy trmt ignored ----------------
        resp = c_ack;
        trmt = 1'b1;
        for (int k = 1; k <= 10 * BD + 1; k++) begin
            cyc(1);
            if (k == 1) trmt = 1'b0;
            if (k == 3 * BD) begin
                resp = 8'h00;
                trmt = 1'b1;
            end
            if (k == 3 * BD + 1) trmt = 1'b0;
            txs[k] = TX;
            dns[k] = tx_done;
        end
        for (int i = 0; i < 8; i++) dec[i] = txs[(i + 1) * BD + BD / 2];
        check("tx_start_next_cycle", txs[1], 0);
        check("tx_start_bit", txs[BD / 2], 0);
        check("tx_byte", dec, 8'hA5);
        check("tx_stop_bit", txs[9 * BD + BD / 2], 1);
        check("tx_done_not_early", dns[10 * BD], 0);
        check("tx_done_on_time", dns[10 * BD + 1], 1);
        t0 = tx_low;
        cyc(2 * BD);
        check("tx_busy_trmt_ignored", tx_low - t0, 0);
        check("tx_done_sticky", tx_done, 1);
        trmt = 1'b1;
        cyc(1);
        trmt = 1'b0;
        cyc(1);
        check("tx_done_cleared_by_trmt", tx_done, 0);
        cyc(10 * BD + 4);

`ifdef OPCODE_FILTER_EN
        // ---------------- opcode filter: NAK for rejected opcodes ----------------
        for (int op = 0; op < 16; op++) begin
            if (op == 2 || op == 3 || op == 4) continue;
            fork
                send_cmd({op[3:0], 4'hF}, 8'hFF, 0);
                capture_tx(cap_b, cap_ok);
            join
            check($sformatf("nak_op%0h_byte", op), cap_b, c_nak);
            check($sformatf("nak_op%0h_frame", op), cap_ok, 1);
            check($sformatf("nak_op%0h_rdy", op), cmd_rdy, 0);
            cyc(BD);
        end
        send_cmd(8'h3F, 8'h00, 0);
        cyc(2);
        check("filter_pass_rdy", cmd_rdy, 1);
        check("filter_pass_cmd", cmd, 16'h3F00);
        pulse_clr();
`else
        // ---------------- no filter: any opcode passes, no autonomous TX ----------------
        t0 = tx_low;
        send_cmd(8'h1F, 8'hFF, 0);
        cyc(BD);
        check("nofilter_rdy", cmd_rdy, 1);
        check("nofilter_cmd", cmd, 16'h1FFF);
        check("nofilter_tx_quiet", tx_low - t0, 0);
        pulse_clr();
`endif

        // ---------------- simultaneous receive and transmit ----------------
        fork
            send_cmd(8'h33, 8'h44, 2);
            begin
                cyc(5 * BD);
                resp = 8'hC3;
                trmt = 1'b1;
                cyc(1);
                trmt = 1'b0;
                capture_tx(cap_b, cap_ok);
            end
        join
        cyc(BD);
        check("dual_tx_byte", cap_b, 8'hC3);
        check("dual_tx_frame", cap_ok, 1);
        check("dual_rx_rdy", cmd_rdy, 1);
        check("dual_rx_cmd", cmd, 16'h3344);
        pulse_clr();
        cyc(2 * BD);

        // ---------------- randomized commands vs reference model ----------------
        m_pending = 1'b0;
        for (int it = 0; it < 16; it++) begin
            r_hi = 8'($urandom);
            r_lo = 8'($urandom);
            gap  = $urandom_range(0, BD);
            skip = 1'($urandom_range(0, 1));
`ifdef OPCODE_FILTER_EN
            m_valid = (r_hi[7:4] >= 4'h2) && (r_hi[7:4] <= 4'h4);
`else
            m_valid = 1'b1;
`endif
            send_byte(r_hi, 1'b1);
            cyc(1);
            check($sformatf("rnd%0d_rdy_after_first", it), cmd_rdy, 0);
            check($sformatf("rnd%0d_cmd_hi", it), cmd[15:8], r_hi);
            cyc(gap);
            send_byte(r_lo, 1'b1);
            cyc(2);
            check($sformatf("rnd%0d_rdy", it), cmd_rdy, m_valid);
            if (m_valid) check($sformatf("rnd%0d_cmd", it), cmd, {r_hi, r_lo});
            if (m_valid && !skip) begin
                pulse_clr();
                check($sformatf("rnd%0d_clr", it), cmd_rdy, 0);
            end
            cyc(BD);
        end
        cyc(12 * BD);

        // ---------------- reset during receive and transmit ----------------
        send_cmd(8'h24, 8'h68, 0);
        cyc(2);
        pulse_clr();
        resp = 8'h3C;
        trmt = 1'b1;
        cyc(1);
        trmt = 1'b0;
        RX = 1'b0;
        cyc(BD);
        RX = 1'b1;
        cyc(BD);
        RX = 1'b0;
        cyc(BD / 2);
        check("pre_reset_tx_low", TX, 0);
        rst = 1'b1;
        RX  = 1'b1;
        cyc(1);
        check("midrst_TX", TX, 1);
        check("midrst_cmd", cmd, 0);
        check("midrst_cmd_rdy", cmd_rdy, 0);
        check("midrst_tx_done", tx_done, 0);
        check("midrst_rx_err", rx_err, 0);
        rst = 1'b0;
        t0 = tx_low;
        e0 = err_cycles;
        cyc(3 * BD);
        check("postrst_tx_quiet", tx_low - t0, 0);
        check("postrst_no_rdy", cmd_rdy, 0);
        send_cmd(8'h42, 8'h99, 1);
        cyc(2);
        check("postrst_rdy", cmd_rdy, 1);
        check("postrst_cmd", cmd, 16'h4299);
        check("postrst_no_err", err_cycles - e0, 0);
        pulse_clr();
        cyc(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
